// File: rtl/arbitro_memoria_dados_pkg.sv
`default_nettype none
// ============================================================================
// Module : arbitro_memoria_dados_pkg
// Brief  : Shared widths, limits and FSM encoding for the data-memory arbiter.
// Rev    : 1.0
// ============================================================================
package arbitro_memoria_dados_pkg;

  localparam int LARGURA_PADRAO    = 8;
  localparam int MAX_ESPERA_PADRAO = 4;
  localparam int ESPERA_W          = 4;

  localparam logic [1:0] S_CORE   = 2'b00;
  localparam logic [1:0] S_LOADER = 2'b01;
  localparam logic [1:0] S_ACK    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/arbitro_memoria_dados_contador_espera.sv
`default_nettype none
// ============================================================================
// Module : arbitro_memoria_dados_contador_espera
// Brief  : Saturating wait counter; clear has priority over increment.
// Rev    : 1.0
// ============================================================================
module arbitro_memoria_dados_contador_espera
  import arbitro_memoria_dados_pkg::*;
#(
  parameter int W = ESPERA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  input  logic [W-1:0] i_limite,
  output logic [W-1:0] o_contagem,
  output logic         o_no_limite
);

  logic [W-1:0] contagem_q;
  logic [W-1:0] contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (i_clr) begin
      contagem_d = '0;
    end else if (i_inc && (contagem_q != i_limite)) begin
      contagem_d = contagem_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign o_contagem  = contagem_q;
  assign o_no_limite = (contagem_q == i_limite);

endmodule
`default_nettype wire

// File: rtl/arbitro_memoria_dados.sv
`default_nettype none
// ============================================================================
// Module : arbitro_memoria_dados
// Brief  : Shares the single-port data memory between the core and a loader.
// Rev    : 1.0
// ============================================================================
module arbitro_memoria_dados
  import arbitro_memoria_dados_pkg::*;
#(
  parameter int LARGURA    = LARGURA_PADRAO,
  parameter int MAX_ESPERA = MAX_ESPERA_PADRAO
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               CoreMemRead,
  input  logic               CoreMemWrite,
  input  logic [LARGURA-1:0] CoreEndereco,
  input  logic [LARGURA-1:0] CoreDadoEscrito,
  output logic [LARGURA-1:0] CoreDadoLido,
  output logic               CoreStall,
  input  logic               LoaderReq,
  input  logic               LoaderWe,
  input  logic [LARGURA-1:0] LoaderEndereco,
  input  logic [LARGURA-1:0] LoaderDado,
  output logic               LoaderAck,
  output logic [LARGURA-1:0] LoaderDadoLido,
  output logic [LARGURA-1:0] MemEndereco,
  output logic [LARGURA-1:0] MemDado,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [LARGURA-1:0] MemDadoLido
);

  localparam logic [ESPERA_W-1:0] ESPERA_LIMITE = ESPERA_W'(MAX_ESPERA);

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [LARGURA-1:0]  loader_dado_lido_q;
  logic [LARGURA-1:0]  loader_dado_lido_d;
  logic                core_busy;
  logic                concede;
  logic                espera_inc;
  logic                espera_clr;
  logic                espera_no_limite;
  logic [ESPERA_W-1:0] espera;

  assign core_busy = CoreMemRead | CoreMemWrite;

  arbitro_memoria_dados_contador_espera #(
    .W (ESPERA_W)
  ) u_contador_espera (
    .clk         (Clock),
    .rst         (Reset),
    .i_inc       (espera_inc),
    .i_clr       (espera_clr),
    .i_limite    (ESPERA_LIMITE),
    .o_contagem  (espera),
    .o_no_limite (espera_no_limite)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q            <= S_CORE;
      loader_dado_lido_q <= '0;
    end else begin
      state_q            <= state_d;
      loader_dado_lido_q <= loader_dado_lido_d;
    end
  end

  // Withdrawing the request in S_CORE also clears the wait count.
  always_comb begin
    state_d    = S_CORE;
    concede    = 1'b0;
    espera_inc = 1'b0;
    espera_clr = 1'b0;
    case (state_q)
      S_CORE: begin
        espera_inc = LoaderReq & core_busy;
        concede    = LoaderReq & (~core_busy | espera_no_limite);
        espera_clr = concede | ~LoaderReq;
        state_d    = concede ? S_LOADER : S_CORE;
      end
      S_LOADER: state_d = S_ACK;
      S_ACK:    state_d = S_CORE;
      default:  state_d = S_CORE;
    endcase
  end

  always_comb begin
    loader_dado_lido_d = loader_dado_lido_q;
    if ((state_q == S_LOADER) && !LoaderWe) begin
      loader_dado_lido_d = MemDadoLido;
    end
  end

  always_comb begin
    MemEndereco  = CoreEndereco;
    MemDado      = CoreDadoEscrito;
    MemWrite     = CoreMemWrite;
    MemRead      = CoreMemRead;
    CoreDadoLido = MemDadoLido;
    CoreStall    = 1'b0;
    LoaderAck    = 1'b0;
    case (state_q)
      S_LOADER: begin
        MemEndereco  = LoaderEndereco;
        MemDado      = LoaderDado;
        MemWrite     = LoaderWe;
        MemRead      = ~LoaderWe;
        CoreDadoLido = '0;
        CoreStall    = 1'b1;
      end
      S_ACK:   LoaderAck = 1'b1;
      default: ;
    endcase
  end

  assign LoaderDadoLido = loader_dado_lido_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria_dados.sv
`default_nettype none
// ============================================================================
// Module : tb_arbitro_memoria_dados
// Brief  : Directed vector table plus a reset-during-grant sequence.
// Rev    : 1.0
// ============================================================================
module tb_arbitro_memoria_dados;

  typedef struct packed {
    logic       crd;
    logic       cwr;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       req;
    logic       we;
    logic [7:0] laddr;
    logic [7:0] ldat;
    logic [7:0] e_maddr;
    logic [7:0] e_mdado;
    logic       e_mwr;
    logic       e_mrd;
    logic       e_stall;
    logic       e_ack;
    logic [7:0] e_crdata;
    logic [7:0] e_ldl;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CoreMemRead;
  logic       CoreMemWrite;
  logic [7:0] CoreEndereco;
  logic [7:0] CoreDadoEscrito;
  logic [7:0] CoreDadoLido;
  logic       CoreStall;
  logic       LoaderReq;
  logic       LoaderWe;
  logic [7:0] LoaderEndereco;
  logic [7:0] LoaderDado;
  logic       LoaderAck;
  logic [7:0] LoaderDadoLido;
  logic [7:0] MemEndereco;
  logic [7:0] MemDado;
  logic       MemWrite;
  logic       MemRead;
  logic [7:0] MemDadoLido;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: unwritten locations read as addr ^ 0x80.
  logic [7:0]   mem [256];
  logic [255:0] escrito = '0;

  always @(posedge Clock) begin
    if (MemWrite) begin
      mem[MemEndereco]     <= MemDado;
      escrito[MemEndereco] <= 1'b1;
    end
  end

  function automatic logic [7:0] mem_valor(input logic [7:0] a);
    return escrito[a] ? mem[a] : (a ^ 8'h80);
  endfunction

  assign MemDadoLido = mem_valor(MemEndereco);

  always #5 Clock = ~Clock;

  arbitro_memoria_dados #(
    .LARGURA    (8),
    .MAX_ESPERA (4)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .CoreMemRead     (CoreMemRead),
    .CoreMemWrite    (CoreMemWrite),
    .CoreEndereco    (CoreEndereco),
    .CoreDadoEscrito (CoreDadoEscrito),
    .CoreDadoLido    (CoreDadoLido),
    .CoreStall       (CoreStall),
    .LoaderReq       (LoaderReq),
    .LoaderWe        (LoaderWe),
    .LoaderEndereco  (LoaderEndereco),
    .LoaderDado      (LoaderDado),
    .LoaderAck       (LoaderAck),
    .LoaderDadoLido  (LoaderDadoLido),
    .MemEndereco     (MemEndereco),
    .MemDado         (MemDado),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .MemDadoLido     (MemDadoLido)
  );

  task automatic chk(input string nome, input logic [7:0] atual, input logic [7:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nome, atual, esperado);
    end
  endtask

  function automatic vec_t v(
    input logic crd, input logic cwr, input logic [7:0] caddr, input logic [7:0] cwd,
    input logic req, input logic we, input logic [7:0] laddr, input logic [7:0] ldat,
    input logic [7:0] maddr, input logic [7:0] mdado, input logic mwr, input logic mrd,
    input logic stall, input logic ack, input logic [7:0] crdata, input logic [7:0] ldl);
    vec_t r;
    r.crd = crd;     r.cwr = cwr;       r.caddr = caddr;  r.cwd = cwd;
    r.req = req;     r.we = we;         r.laddr = laddr;  r.ldat = ldat;
    r.e_maddr = maddr; r.e_mdado = mdado; r.e_mwr = mwr;  r.e_mrd = mrd;
    r.e_stall = stall; r.e_ack = ack;   r.e_crdata = crdata; r.e_ldl = ldl;
    return r;
  endfunction

  vec_t vecs [33];

  initial begin
    // Idle-core write 0x20 <= A5; core reads it back in the ack cycle.
    vecs[0]  = v(0,0,8'h00,8'h00, 1,1,8'h20,8'hA5, 8'h00,8'h00,0,0,0,0,8'h80,8'h00);
    vecs[1]  = v(0,0,8'h00,8'h00, 1,1,8'h20,8'hA5, 8'h20,8'hA5,1,0,1,0,8'h00,8'h00);
    vecs[2]  = v(1,0,8'h20,8'h00, 1,1,8'h20,8'hA5, 8'h20,8'h00,0,1,0,1,8'hA5,8'h00);
    vecs[3]  = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,8'h00,0,0,0,0,8'h80,8'h00);
    // Idle-core loader read of 0x20, data held after ack.
    vecs[4]  = v(0,0,8'h05,8'h00, 1,0,8'h20,8'h00, 8'h05,8'h00,0,0,0,0,8'h85,8'h00);
    vecs[5]  = v(0,0,8'h05,8'h00, 1,0,8'h20,8'h00, 8'h20,8'h00,0,1,1,0,8'h00,8'h00);
    vecs[6]  = v(0,0,8'h05,8'h00, 1,0,8'h20,8'h00, 8'h05,8'h00,0,0,0,1,8'h85,8'hA5);
    vecs[7]  = v(0,0,8'h05,8'h00, 0,0,8'h00,8'h00, 8'h05,8'h00,0,0,0,0,8'h85,8'hA5);
    // Request held across two beats: an S_CORE cycle must separate them.
    vecs[8]  = v(0,0,8'h00,8'h00, 1,1,8'h30,8'h11, 8'h00,8'h00,0,0,0,0,8'h80,8'hA5);
    vecs[9]  = v(0,0,8'h00,8'h00, 1,1,8'h30,8'h11, 8'h30,8'h11,1,0,1,0,8'h00,8'hA5);
    vecs[10] = v(0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 8'h00,8'h00,0,0,0,1,8'h80,8'hA5);
    vecs[11] = v(0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 8'h00,8'h00,0,0,0,0,8'h80,8'hA5);
    vecs[12] = v(0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 8'h30,8'h00,0,1,1,0,8'h00,8'hA5);
    vecs[13] = v(0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 8'h00,8'h00,0,0,0,1,8'h80,8'h11);
    vecs[14] = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,8'h00,0,0,0,0,8'h80,8'h11);
    // Core store 0x05 <= 33 as the request rises, then busy core forces grant.
    vecs[15] = v(0,1,8'h05,8'h33, 1,0,8'h05,8'h00, 8'h05,8'h33,1,0,0,0,8'h85,8'h11);
    vecs[16] = v(1,0,8'h05,8'h00, 1,0,8'h05,8'h00, 8'h05,8'h00,0,1,0,0,8'h33,8'h11);
    vecs[17] = v(1,0,8'h20,8'h00, 1,0,8'h05,8'h00, 8'h20,8'h00,0,1,0,0,8'hA5,8'h11);
    vecs[18] = v(1,0,8'h30,8'h00, 1,0,8'h05,8'h00, 8'h30,8'h00,0,1,0,0,8'h11,8'h11);
    vecs[19] = v(1,0,8'h10,8'h00, 1,0,8'h05,8'h00, 8'h10,8'h00,0,1,0,0,8'h90,8'h11);
    vecs[20] = v(1,0,8'h00,8'h00, 1,0,8'h05,8'h00, 8'h05,8'h00,0,1,1,0,8'h00,8'h11);
    vecs[21] = v(1,0,8'h00,8'h00, 1,0,8'h05,8'h00, 8'h00,8'h00,0,1,0,1,8'h80,8'h33);
    vecs[22] = v(1,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,8'h00,0,1,0,0,8'h80,8'h33);
    // Withdrawn request clears the wait count; full wait restarts.
    vecs[23] = v(1,0,8'h00,8'h00, 1,0,8'h20,8'h00, 8'h00,8'h00,0,1,0,0,8'h80,8'h33);
    vecs[24] = v(1,0,8'h00,8'h00, 1,0,8'h20,8'h00, 8'h00,8'h00,0,1,0,0,8'h80,8'h33);
    vecs[25] = v(1,0,8'h00,8'h00, 0,0,8'h20,8'h00, 8'h00,8'h00,0,1,0,0,8'h80,8'h33);
    for (int k = 26; k <= 30; k++)
      vecs[k] = v(1,0,8'h00,8'h00, 1,0,8'h20,8'h00, 8'h00,8'h00,0,1,0,0,8'h80,8'h33);
    vecs[31] = v(1,0,8'h00,8'h00, 1,0,8'h20,8'h00, 8'h20,8'h00,0,1,1,0,8'h00,8'h33);
    vecs[32] = v(1,0,8'h00,8'h00, 1,0,8'h20,8'h00, 8'h00,8'h00,0,1,0,1,8'h80,8'hA5);

    Reset           = 1'b1;
    CoreMemRead     = 1'b1;
    CoreMemWrite    = 1'b0;
    CoreEndereco    = 8'h07;
    CoreDadoEscrito = 8'h00;
    LoaderReq       = 1'b0;
    LoaderWe        = 1'b0;
    LoaderEndereco  = 8'h00;
    LoaderDado      = 8'h00;

    @(negedge Clock);
    chk("rst stall", {7'b0, CoreStall}, 8'h00);
    chk("rst ack", {7'b0, LoaderAck}, 8'h00);
    chk("rst ldl", LoaderDadoLido, 8'h00);
    chk("rst mem_rd", {7'b0, MemRead}, 8'h01);
    chk("rst mem_addr", MemEndereco, 8'h07);
    chk("rst core_rdata", CoreDadoLido, 8'h87);
    @(posedge Clock);
    #1 Reset = 1'b0;

    for (int i = 0; i < 33; i++) begin
      CoreMemRead     = vecs[i].crd;
      CoreMemWrite    = vecs[i].cwr;
      CoreEndereco    = vecs[i].caddr;
      CoreDadoEscrito = vecs[i].cwd;
      LoaderReq       = vecs[i].req;
      LoaderWe        = vecs[i].we;
      LoaderEndereco  = vecs[i].laddr;
      LoaderDado      = vecs[i].ldat;
      @(negedge Clock);
      chk($sformatf("v%0d mem_addr", i), MemEndereco, vecs[i].e_maddr);
      chk($sformatf("v%0d mem_dado", i), MemDado, vecs[i].e_mdado);
      chk($sformatf("v%0d mem_wr", i), {7'b0, MemWrite}, {7'b0, vecs[i].e_mwr});
      chk($sformatf("v%0d mem_rd", i), {7'b0, MemRead}, {7'b0, vecs[i].e_mrd});
      chk($sformatf("v%0d stall", i), {7'b0, CoreStall}, {7'b0, vecs[i].e_stall});
      chk($sformatf("v%0d ack", i), {7'b0, LoaderAck}, {7'b0, vecs[i].e_ack});
      chk($sformatf("v%0d core_rdata", i), CoreDadoLido, vecs[i].e_crdata);
      chk($sformatf("v%0d ldl", i), LoaderDadoLido, vecs[i].e_ldl);
      @(posedge Clock);
      #1;
    end

    // Reset lands while a loader write to 0x10 owns the port.
    CoreMemRead    = 1'b0;
    CoreMemWrite   = 1'b0;
    CoreEndereco   = 8'h00;
    LoaderReq      = 1'b1;
    LoaderWe       = 1'b1;
    LoaderEndereco = 8'h10;
    LoaderDado     = 8'h55;
    @(negedge Clock);
    chk("rl grant stall", {7'b0, CoreStall}, 8'h00);
    @(posedge Clock);
    #1;
    @(negedge Clock);
    chk("rl mem_wr", {7'b0, MemWrite}, 8'h01);
    chk("rl mem_addr", MemEndereco, 8'h10);
    #2 Reset = 1'b1;
    #1;
    chk("rl mem_wr drop", {7'b0, MemWrite}, 8'h00);
    chk("rl stall drop", {7'b0, CoreStall}, 8'h00);
    chk("rl mem_addr core", MemEndereco, 8'h00);
    chk("rl ldl", LoaderDadoLido, 8'h00);
    LoaderReq = 1'b0;
    @(posedge Clock);
    #1 Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      chk($sformatf("rl no_ack%0d", c), {7'b0, LoaderAck}, 8'h00);
      @(posedge Clock);
      #1;
    end
    chk("rl mem10", mem_valor(8'h10), 8'h90);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
